// File: rtl/sci_tx_frame_sched_if.sv
// Signal bundle between the SCI frame scheduler (master) and its requesters plus the
// byte-level SCI transmitter (slave).
interface sci_tx_frame_sched_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]    req;
  logic [16*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    ack;
  logic                tx_ready;
  logic                tx_start;
  logic [7:0]          tx_data;
  logic                busy;
  logic                frame_done;

  modport master (
    input  req, req_data, tx_ready,
    output ack, tx_start, tx_data, busy, frame_done
  );

  modport slave (
    output req, req_data, tx_ready,
    input  ack, tx_start, tx_data, busy, frame_done
  );
endinterface

// File: rtl/sci_tx_frame_sched.sv
// Round-robin scheduler framing 16-bit words as HEADER, ID, DATA_HI, DATA_LO for the SCI transmitter.
// Define SCI_TX_CHECKSUM_EN to append a fifth XOR checksum byte to every frame.
module sci_tx_frame_sched #(
  parameter int         N_REQ   = 4,
  parameter logic [7:0] HEADER  = 8'hA5,
  parameter int         BUSY_TO = 3
) (
  input  logic                 baud_clk,
  input  logic                 rst_n,
  sci_tx_frame_sched_if.master bus
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = (BUSY_TO < 1) ? 1 : $clog2(BUSY_TO + 1);

`ifdef SCI_TX_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd4;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [15:0]      word_q, word_d;
  logic [2:0]       byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand_idx;
  int               cand;
  logic [7:0]       id_byte;
  logic [7:0]       cur_byte;

  // Walk downward so the requester closest after last_grant is the one left selected.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = last_grant_q;
    cand       = 0;
    cand_idx   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = int'(last_grant_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = IDX_W'(cand);
      if (bus.req[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign id_byte = 8'(grant_idx_q);

`ifdef SCI_TX_CHECKSUM_EN
  logic [7:0] chk_byte;
  assign chk_byte = HEADER ^ id_byte ^ word_q[15:8] ^ word_q[7:0];
`endif

  always_comb begin
    cur_byte = HEADER;
    case (byte_idx_q)
      3'd0:    cur_byte = HEADER;
      3'd1:    cur_byte = id_byte;
      3'd2:    cur_byte = word_q[15:8];
      3'd3:    cur_byte = word_q[7:0];
`ifdef SCI_TX_CHECKSUM_EN
      3'd4:    cur_byte = chk_byte;
`endif
      default: cur_byte = HEADER;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_idx_d  = grant_idx_q;
    word_d       = word_q;
    byte_idx_d   = byte_idx_q;
    to_cnt_d     = to_cnt_q;
    ack_d        = '0;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          last_grant_d    = pick_idx;
          grant_idx_d     = pick_idx;
          word_d          = bus.req_data[int'(pick_idx)*16 +: 16];
          ack_d[pick_idx] = 1'b1;
          busy_d          = 1'b1;
          byte_idx_d      = 3'd0;
          state_d         = LOAD;
        end
      end
      LOAD: begin
        tx_data_d = cur_byte;
        if (bus.tx_ready) begin
          tx_start_d = 1'b1;
          to_cnt_d   = '0;
          state_d    = WAIT_BUSY;
        end
      end
      // A transmitter that never goes busy missed the edge; LOAD re-pulses the same byte.
      WAIT_BUSY: begin
        if (!bus.tx_ready) begin
          state_d = WAIT_DONE;
        end else if (to_cnt_q == CNT_W'(BUSY_TO)) begin
          state_d = LOAD;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (bus.tx_ready) begin
          if (byte_idx_q == LAST_IDX) begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
            state_d    = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(N_REQ - 1);
      grant_idx_q  <= '0;
      word_q       <= '0;
      byte_idx_q   <= '0;
      to_cnt_q     <= '0;
      ack_q        <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_idx_q  <= grant_idx_d;
      word_q       <= word_d;
      byte_idx_q   <= byte_idx_d;
      to_cnt_q     <= to_cnt_d;
      ack_q        <= ack_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.ack        = ack_q;
  assign bus.tx_start   = tx_start_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_sci_tx_frame_sched.sv
// Bench for sci_tx_frame_sched: behavioural SCI transmitter, requester driving and a
// frame-level reference model (round-robin order and byte contents from the framing rules).
module tb_sci_tx_frame_sched;

  localparam int         N_REQ   = 4;
  localparam logic [7:0] HEADER  = 8'hA5;
  localparam int         BUSY_TO = 3;
`ifdef SCI_TX_CHECKSUM_EN
  localparam int FRAME_LEN = 5;
`else
  localparam int FRAME_LEN = 4;
`endif

  localparam int TX_NORMAL     = 0;
  localparam int TX_STUCK_HIGH = 1;
  localparam int TX_FORCED_LOW = 2;

  logic baud_clk = 1'b0;
  logic rst_n    = 1'b0;
  always #5 baud_clk = ~baud_clk;

  sci_tx_frame_sched_if #(.N_REQ(N_REQ)) bus ();

  sci_tx_frame_sched #(
    .N_REQ  (N_REQ),
    .HEADER (HEADER),
    .BUSY_TO(BUSY_TO)
  ) dut (
    .baud_clk(baud_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int tx_mode = TX_FORCED_LOW;

  always @(posedge baud_clk) cycle++;

  // Transmitter model: tx_ready drops about 2 cycles after a tx_start rise and returns 77 cycles later.
  int   tx_delay = 0;
  int   tx_low   = 0;
  logic tx_start_prev = 1'b0;
  always @(negedge baud_clk) begin
    if (tx_mode == TX_FORCED_LOW) begin
      tx_delay     = 0;
      tx_low       = 0;
      bus.tx_ready = 1'b0;
    end else if (tx_mode == TX_STUCK_HIGH) begin
      tx_delay     = 0;
      tx_low       = 0;
      bus.tx_ready = 1'b1;
    end else begin
      if (tx_low > 0) begin
        tx_low--;
      end else if (tx_delay > 0) begin
        tx_delay--;
        if (tx_delay == 0) tx_low = 77;
      end else if (bus.tx_start && !tx_start_prev) begin
        tx_delay = 1;
      end
      bus.tx_ready = (tx_low == 0);
    end
    tx_start_prev = bus.tx_start;
  end

  // Monitor logs every transmitted byte, pulse time, grant and completed frame.
  logic [7:0] byte_log[$];
  int         pulse_cycles[$];
  int         grant_log[$];
  int         done_cnt = 0;
  logic       mon_start_prev = 1'b0;
  always @(negedge baud_clk) begin
    if (rst_n) begin
      if (bus.tx_start && !mon_start_prev) begin
        byte_log.push_back(bus.tx_data);
        pulse_cycles.push_back(cycle);
      end
      for (int i = 0; i < N_REQ; i++)
        if (bus.ack[i]) grant_log.push_back(i);
      if (bus.frame_done) done_cnt++;
    end
    mon_start_prev = bus.tx_start;
  end

  logic [15:0] words[N_REQ];

  function automatic logic [7:0] exp_byte(input int idx, input logic [15:0] w, input int k);
    logic [7:0] id;
    id = 8'(idx);
    case (k)
      0:       return HEADER;
      1:       return id;
      2:       return w[15:8];
      3:       return w[7:0];
      default: return HEADER ^ id ^ w[15:8] ^ w[7:0];
    endcase
  endfunction

  function automatic int next_grant(input int last, input logic [N_REQ-1:0] mask);
    for (int off = 1; off <= N_REQ; off++) begin
      int i;
      i = (last + off) % N_REQ;
      if (mask[i]) return i;
    end
    return -1;
  endfunction

  task automatic load_words();
    for (int i = 0; i < N_REQ; i++) bus.req_data[16*i +: 16] = words[i];
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    bus.req = '0;
    tx_mode = TX_FORCED_LOW;
    repeat (2) @(negedge baud_clk);
    tx_mode = TX_NORMAL;
    @(negedge baud_clk);
    rst_n = 1'b1;
    @(negedge baud_clk);
  endtask

  task automatic serve_acks(input int budget, output bit ok);
    int n;
    n = 0;
    while (bus.req != '0 && n < budget) begin
      @(negedge baud_clk);
      bus.req = bus.req & ~bus.ack;
      n++;
    end
    ok = (bus.req == '0);
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(posedge baud_clk);
      n++;
    end
    ok = (done_cnt >= target);
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    tx_mode      = TX_FORCED_LOW;
    repeat (2) @(negedge baud_clk);
    checks++; if (bus.ack !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ack: got %b expected 0000", bus.ack); end
    checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_start: got %b expected 0", bus.tx_start); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_data: got %h expected 00", bus.tx_data); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done: got %b expected 0", bus.frame_done); end
    tx_mode = TX_NORMAL;
    @(negedge baud_clk);
    rst_n = 1'b1;
    @(negedge baud_clk);
  endtask

  task automatic test_single_request();
    int b0, d0;
    bit ok;
    apply_reset();
    for (int i = 0; i < N_REQ; i++) words[i] = 16'($urandom);
    words[2] = 16'h1234;
    load_words();
    b0 = byte_log.size();
    d0 = done_cnt;
    bus.req = 4'b0100;
    @(negedge baud_clk);
    checks++; if (bus.ack !== 4'b0100) begin errors++; $display("[TB] FAIL single_ack: got %b expected 0100", bus.ack); end
    bus.req = '0;
    @(negedge baud_clk);
    checks++; if (bus.ack !== 4'b0000) begin errors++; $display("[TB] FAIL single_ack_width: got %b expected 0000", bus.ack); end
    checks++; if (bus.tx_start !== 1'b1) begin errors++; $display("[TB] FAIL single_first_start: got %b expected 1", bus.tx_start); end
    wait_done(d0 + 1, 1000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL single_timeout: got no frame_done expected one"); end
    @(negedge baud_clk);
    checks++; if (byte_log.size() - b0 !== FRAME_LEN) begin errors++; $display("[TB] FAIL single_byte_count: got %0d expected %0d", byte_log.size() - b0, FRAME_LEN); end
    if (byte_log.size() - b0 >= FRAME_LEN)
      for (int k = 0; k < FRAME_LEN; k++) begin
        checks++;
        if (byte_log[b0+k] !== exp_byte(2, words[2], k)) begin
          errors++; $display("[TB] FAIL single_byte%0d: got %h expected %h", k, byte_log[b0+k], exp_byte(2, words[2], k));
        end
      end
    checks++; if (done_cnt !== d0 + 1) begin errors++; $display("[TB] FAIL single_done_count: got %0d expected %0d", done_cnt - d0, 1); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_after: got %b expected 0", bus.busy); end
  endtask

  task automatic test_all_requesting();
    int b0, g0, d0, last, g;
    bit ok;
    apply_reset();
    for (int i = 0; i < N_REQ; i++) words[i] = {8'(i), 8'(i)};
    load_words();
    b0 = byte_log.size();
    g0 = grant_log.size();
    d0 = done_cnt;
    bus.req = 4'b1111;
    wait_done(d0 + 5, 3000, ok);
    bus.req = '0;
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL rotate_timeout: got %0d frames expected 5", done_cnt - d0); end
    if (ok && grant_log.size() >= g0 + 5 && byte_log.size() >= b0 + 5*FRAME_LEN) begin
      last = N_REQ - 1;
      for (int f = 0; f < 5; f++) begin
        g = next_grant(last, 4'b1111);
        last = g;
        checks++;
        if (grant_log[g0+f] !== g) begin errors++; $display("[TB] FAIL rotate_grant%0d: got %0d expected %0d", f, grant_log[g0+f], g); end
        for (int k = 0; k < FRAME_LEN; k++) begin
          checks++;
          if (byte_log[b0+f*FRAME_LEN+k] !== exp_byte(g, words[g], k)) begin
            errors++; $display("[TB] FAIL rotate_f%0d_byte%0d: got %h expected %h", f, k, byte_log[b0+f*FRAME_LEN+k], exp_byte(g, words[g], k));
          end
        end
      end
    end
  endtask

  task automatic test_random_rounds();
    int b0, g0, d0, last, g, nf;
    int order[$];
    logic [N_REQ-1:0] mask, remaining;
    bit ok;
    apply_reset();
    last = N_REQ - 1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N_REQ; i++) words[i] = 16'($urandom);
      load_words();
      mask = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      order.delete();
      remaining = mask;
      while (remaining != '0) begin
        g = next_grant(last, remaining);
        order.push_back(g);
        remaining[g] = 1'b0;
        last = g;
      end
      b0 = byte_log.size();
      g0 = grant_log.size();
      d0 = done_cnt;
      nf = order.size();
      bus.req = mask;
      serve_acks(600 * N_REQ, ok);
      bus.req = '0;
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL rand%0d_acks: got req %b expected 0000", r, mask); end
      wait_done(d0 + nf, 600 * nf, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL rand%0d_frames: got %0d expected %0d", r, done_cnt - d0, nf); end
      @(negedge baud_clk);
      if (grant_log.size() >= g0 + nf && byte_log.size() >= b0 + nf*FRAME_LEN) begin
        for (int j = 0; j < nf; j++) begin
          checks++;
          if (grant_log[g0+j] !== order[j]) begin errors++; $display("[TB] FAIL rand%0d_grant%0d: got %0d expected %0d", r, j, grant_log[g0+j], order[j]); end
          for (int k = 0; k < FRAME_LEN; k++) begin
            checks++;
            if (byte_log[b0+j*FRAME_LEN+k] !== exp_byte(order[j], words[order[j]], k)) begin
              errors++; $display("[TB] FAIL rand%0d_f%0d_byte%0d: got %h expected %h", r, j, k, byte_log[b0+j*FRAME_LEN+k], exp_byte(order[j], words[order[j]], k));
            end
          end
        end
      end else begin
        checks++; errors++;
        $display("[TB] FAIL rand%0d_log: got %0d grants expected %0d", r, grant_log.size() - g0, nf);
      end
    end
  endtask

  task automatic test_busy_timeout();
    int p0, d0, np;
    bit ok;
    apply_reset();
    tx_mode = TX_STUCK_HIGH;
    @(negedge baud_clk);
    words[0] = 16'($urandom);
    load_words();
    p0 = pulse_cycles.size();
    d0 = done_cnt;
    bus.req = 4'b0001;
    serve_acks(20, ok);
    repeat (30) @(posedge baud_clk);
    np = pulse_cycles.size() - p0;
    checks++; if ((np >= 4) !== 1'b1) begin errors++; $display("[TB] FAIL timeout_pulses: got %0d expected at least 4", np); end
    if (np >= 4)
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (pulse_cycles[p0+k+1] - pulse_cycles[p0+k] !== BUSY_TO + 2) begin
          errors++; $display("[TB] FAIL timeout_period%0d: got %0d expected %0d", k, pulse_cycles[p0+k+1] - pulse_cycles[p0+k], BUSY_TO + 2);
        end
        checks++;
        if (byte_log[p0+k+1] !== HEADER) begin errors++; $display("[TB] FAIL timeout_data%0d: got %h expected %h", k, byte_log[p0+k+1], HEADER); end
      end
    @(negedge baud_clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL timeout_busy: got %b expected 1", bus.busy); end
    checks++; if (done_cnt !== d0) begin errors++; $display("[TB] FAIL timeout_no_done: got %0d expected 0", done_cnt - d0); end
    apply_reset();
  endtask

  task automatic test_ready_low_start();
    int b0, d0;
    bit ok;
    apply_reset();
    tx_mode = TX_FORCED_LOW;
    for (int i = 0; i < N_REQ; i++) words[i] = 16'($urandom);
    load_words();
    b0 = byte_log.size();
    d0 = done_cnt;
    @(negedge baud_clk);
    bus.req = 4'b0010;
    serve_acks(20, ok);
    repeat (10) @(negedge baud_clk);
    checks++; if (byte_log.size() - b0 !== 0) begin errors++; $display("[TB] FAIL ready_low_no_start: got %0d pulses expected 0", byte_log.size() - b0); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL ready_low_busy: got %b expected 1", bus.busy); end
    tx_mode = TX_NORMAL;
    repeat (6) @(negedge baud_clk);
    checks++; if (byte_log.size() - b0 !== 1) begin errors++; $display("[TB] FAIL ready_low_one_pulse: got %0d pulses expected 1", byte_log.size() - b0); end
    wait_done(d0 + 1, 1000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL ready_low_timeout: got no frame_done expected one"); end
    @(negedge baud_clk);
    if (byte_log.size() - b0 >= FRAME_LEN)
      for (int k = 0; k < FRAME_LEN; k++) begin
        checks++;
        if (byte_log[b0+k] !== exp_byte(1, words[1], k)) begin
          errors++; $display("[TB] FAIL ready_low_byte%0d: got %h expected %h", k, byte_log[b0+k], exp_byte(1, words[1], k));
        end
      end
  endtask

  task automatic test_reset_mid_frame();
    int b0, d0, n;
    bit ok;
    apply_reset();
    for (int i = 0; i < N_REQ; i++) words[i] = 16'($urandom);
    load_words();
    b0 = byte_log.size();
    d0 = done_cnt;
    bus.req = 4'b0100;
    serve_acks(20, ok);
    n = 0;
    while (byte_log.size() < b0 + 3 && n < 1000) begin @(posedge baud_clk); n++; end
    checks++; if (byte_log.size() < b0 + 3) begin errors++; $display("[TB] FAIL midreset_reach_byte2: got %0d bytes expected 3", byte_log.size() - b0); end
    @(posedge baud_clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.tx_start !== 1'b0) begin errors++; $display("[TB] FAIL midreset_tx_start: got %b expected 0", bus.tx_start); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("[TB] FAIL midreset_tx_data: got %h expected 00", bus.tx_data); end
    checks++; if (bus.ack !== 4'b0000) begin errors++; $display("[TB] FAIL midreset_ack: got %b expected 0000", bus.ack); end
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_frame_done: got %b expected 0", bus.frame_done); end
    tx_mode = TX_FORCED_LOW;
    repeat (2) @(negedge baud_clk);
    tx_mode = TX_NORMAL;
    @(negedge baud_clk);
    rst_n = 1'b1;
    @(negedge baud_clk);
    words[0] = 16'($urandom);
    load_words();
    b0 = byte_log.size();
    bus.req = 4'b0001;
    serve_acks(20, ok);
    wait_done(d0 + 1, 1000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL midreset_timeout: got no frame_done expected one"); end
    @(negedge baud_clk);
    checks++; if (done_cnt !== d0 + 1) begin errors++; $display("[TB] FAIL midreset_done_count: got %0d expected 1", done_cnt - d0); end
    checks++; if (byte_log.size() - b0 !== FRAME_LEN) begin errors++; $display("[TB] FAIL midreset_byte_count: got %0d expected %0d", byte_log.size() - b0, FRAME_LEN); end
    if (byte_log.size() - b0 >= FRAME_LEN)
      for (int k = 0; k < FRAME_LEN; k++) begin
        checks++;
        if (byte_log[b0+k] !== exp_byte(0, words[0], k)) begin
          errors++; $display("[TB] FAIL midreset_byte%0d: got %h expected %h", k, byte_log[b0+k], exp_byte(0, words[0], k));
        end
      end
  endtask

  task automatic test_drop_before_grant();
    int g0, d0, ones;
    bit ok;
    apply_reset();
    for (int i = 0; i < N_REQ; i++) words[i] = 16'($urandom);
    load_words();
    g0 = grant_log.size();
    d0 = done_cnt;
    bus.req = 4'b0001;
    serve_acks(20, ok);
    repeat (3) @(negedge baud_clk);
    bus.req[1] = 1'b1;
    repeat (2) @(negedge baud_clk);
    bus.req[1] = 1'b0;
    wait_done(d0 + 1, 1000, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL drop_timeout: got no frame_done expected one"); end
    repeat (10) @(negedge baud_clk);
    ones = 0;
    for (int j = g0; j < grant_log.size(); j++) if (grant_log[j] == 1) ones++;
    checks++; if (ones !== 0) begin errors++; $display("[TB] FAIL drop_never_acked: got %0d acks expected 0", ones); end
    checks++; if (grant_log.size() - g0 !== 1) begin errors++; $display("[TB] FAIL drop_grant_count: got %0d expected 1", grant_log.size() - g0); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL drop_idle_after: got %b expected 0", bus.busy); end
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got time limit expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.req      = '0;
    bus.req_data = '0;
    test_reset();
    test_single_request();
    test_all_requesting();
    test_random_rounds();
    test_busy_timeout();
    test_ready_low_start();
    test_reset_mid_frame();
    test_drop_before_grant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
